// File: rtl/can_bit_timing.sv
// can_bit_timing: CAN bit timing with hard/re-synchronization and sample-point strobe
module can_bit_timing #(
  parameter int BRP        = 4,
  parameter int PROP_SEG   = 2,
  parameter int PHASE_SEG1 = 3,
  parameter int PHASE_SEG2 = 3,
  parameter int SJW        = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic RX,
  input  logic hard_sync_en,
  output logic SP,
  output logic sp_bit,
  output logic bit_start
);
  typedef enum logic [1:0] {SYNC, PS1, PS2} state_t;
  localparam logic [5:0] PRE_LAST = 6'(BRP - 1);
  localparam logic [4:0] PS1_BASE = 5'(PROP_SEG + PHASE_SEG1 - 1);
  localparam logic [4:0] PS2_LEN  = 5'(PHASE_SEG2);
  localparam logic [4:0] SJW_W    = 5'(SJW);
  localparam logic [2:0] SJW_3    = 3'(SJW);
  logic       rx_meta_q, rx_s_q, rx_prev_q;
  state_t     state_q, state_d;
  logic [5:0] pre_q, pre_d;
  logic [4:0] tq_q, tq_d, inc, cnt2;
  logic [2:0] ext_q, ext_d, shr_q, shr_d;
  logic       ok_q, ok_d, sp_q, sp_bit_q;
  logic       fall, tq_tick, sample, ps2_end, hs, rs, rs_ps1, rs_ps2, rs_hard, force_sync, take;
  assign fall       = rx_prev_q & ~rx_s_q;
  assign tq_tick    = pre_q == PRE_LAST;
  assign inc        = tq_q + 5'd1;
  assign sample     = state_q == PS1 && tq_tick && tq_q == PS1_BASE + {2'b0, ext_q};
  assign ps2_end    = state_q == PS2 && tq_tick && tq_q + {2'b0, shr_q} + 5'd1 >= PS2_LEN;
  assign hs         = fall & hard_sync_en;
  assign rs         = fall & ~hard_sync_en & ok_q;
  assign rs_ps1     = rs && state_q == PS1 && !sample;
  assign rs_ps2     = rs && (state_q == PS2 || sample) && !ps2_end;
  assign cnt2       = sample ? 5'd0 : tq_q;
  assign rs_hard    = rs_ps2 && PS2_LEN - cnt2 <= SJW_W;
  assign force_sync = hs | rs_hard;
  assign take       = sample & ~hs;
  assign SP         = sp_q;
  assign sp_bit     = sp_bit_q;
  assign bit_start  = reset && state_q == SYNC && pre_q == 6'd0;
  // two-flop RX synchronizer plus one-clk delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {rx_meta_q, rx_s_q, rx_prev_q} <= 3'b111;
    else {rx_meta_q, rx_s_q, rx_prev_q} <= {RX, rx_meta_q, rx_s_q};
  end
  // segment sequencing, resync adjustments and forced SYNC (hard sync wins last)
  always_comb begin
    state_d = state_q;
    pre_d   = tq_tick ? 6'd0 : pre_q + 6'd1;
    tq_d    = tq_q;
    ext_d   = ext_q;
    shr_d   = shr_q;
    ok_d    = ok_q;
    if (rs_ps1) begin
      ext_d = inc < SJW_W ? inc[2:0] : SJW_3;
      ok_d  = 1'b0;
    end
    if (rs_ps2) begin
      shr_d = SJW_3;
      ok_d  = 1'b0;
    end
    if (tq_tick) begin
      tq_d = inc;
      if (state_q == SYNC) begin
        state_d = PS1;
        tq_d    = 5'd0;
      end else if (sample) begin
        state_d = PS2;
        tq_d    = 5'd0;
      end else if (state_q == PS2 && tq_q + {2'b0, shr_d} + 5'd1 >= PS2_LEN) begin
        state_d = SYNC;
        tq_d    = 5'd0;
        ext_d   = 3'd0;
        shr_d   = 3'd0;
        ok_d    = 1'b1;
      end
    end
    if (force_sync) begin
      state_d = SYNC;
      pre_d   = 6'd0;
      tq_d    = 5'd0;
      ext_d   = 3'd0;
      shr_d   = 3'd0;
      ok_d    = 1'b1;
    end
  end
  // timing state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SYNC;
      pre_q   <= 6'd0;
      tq_q    <= 5'd0;
      ext_q   <= 3'd0;
      shr_q   <= 3'd0;
      ok_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tq_q    <= tq_d;
      ext_q   <= ext_d;
      shr_q   <= shr_d;
      ok_q    <= ok_d;
    end
  end
  // sample-point strobe one clk after the sample condition, capturing the synchronized bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q     <= 1'b0;
      sp_bit_q <= 1'b1;
    end else begin
      sp_q     <= take;
      sp_bit_q <= take ? rx_s_q : sp_bit_q;
    end
  end
endmodule
